// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I decode constants and ID/EX control-word types.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_J = 2'b01,
    IMM_B = 2'b10,
    IMM_S = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_BR  = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    logic    utype;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/decode_ctrl_if.sv
// Fetch/decode/execute handshake bundle around the decode controller.
interface decode_ctrl_if #(
  parameter int XLEN = 32
);

  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic            id_ready;
  logic [1:0]      imm_sel;
  logic            ex_hold;
  logic            ex_flush;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_alu_src;
  logic            ex_utype;
  logic            ex_illegal;
  logic [1:0]      ex_alu_op;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;

  modport master (
    output id_valid, id_instr, ex_hold, ex_flush,
    input  id_ready, imm_sel, ex_valid,
    input  ex_reg_write, ex_mem_read, ex_mem_write,
    input  ex_branch, ex_jump, ex_alu_src,
    input  ex_utype, ex_illegal, ex_alu_op,
    input  ex_rd, ex_rs1, ex_rs2
  );

  modport slave (
    input  id_valid, id_instr, ex_hold, ex_flush,
    output id_ready, imm_sel, ex_valid,
    output ex_reg_write, ex_mem_read, ex_mem_write,
    output ex_branch, ex_jump, ex_alu_src,
    output ex_utype, ex_illegal, ex_alu_op,
    output ex_rd, ex_rs1, ex_rs2
  );

endinterface

// File: rtl/decode_table.sv
// Combinational opcode decode: control word, imm format, rs usage.
module decode_table
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic       i_valid,
  output ctrl_t      o_ctrl,
  output imm_sel_e   o_imm_sel,
  output logic       o_use_rs1,
  output logic       o_use_rs2
);

  logic w_load, w_opimm, w_jalr, w_store;
  logic w_branch, w_jal, w_lui, w_auipc, w_op;

  assign w_load   = (i_opcode == OPC_LOAD);
  assign w_opimm  = (i_opcode == OPC_OPIMM);
  assign w_jalr   = (i_opcode == OPC_JALR);
  assign w_store  = (i_opcode == OPC_STORE);
  assign w_branch = (i_opcode == OPC_BRANCH);
  assign w_jal    = (i_opcode == OPC_JAL);
  assign w_lui    = (i_opcode == OPC_LUI);
  assign w_auipc  = (i_opcode == OPC_AUIPC);
  assign w_op     = (i_opcode == OPC_OP);

  always_comb begin
    o_ctrl    = '0;
    o_imm_sel = IMM_I;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    unique case (1'b1)
      w_load: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_use_rs1        = 1'b1;
      end
      w_opimm: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_I;
        o_use_rs1        = 1'b1;
      end
      w_jalr: begin
        o_ctrl.jump      = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_use_rs1        = 1'b1;
      end
      w_store: begin
        o_imm_sel        = IMM_S;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_use_rs1        = 1'b1;
        o_use_rs2        = 1'b1;
      end
      w_branch: begin
        o_imm_sel     = IMM_B;
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_BR;
        o_use_rs1     = 1'b1;
        o_use_rs2     = 1'b1;
      end
      w_jal: begin
        o_imm_sel        = IMM_J;
        o_ctrl.jump      = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      w_lui, w_auipc: begin
        o_ctrl.utype     = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      w_op: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_R;
        o_use_rs1        = 1'b1;
        o_use_rs2        = 1'b1;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
    // immediate generator idles on I when nothing is presented
    if (!i_valid) o_imm_sel = IMM_I;
  end

endmodule

// File: rtl/decode_ctrl.sv
// ID-stage controller: decode, stall/flush/hold priority, ID/EX register.
// Load-use stalls only when DECODE_CTRL_HAZARD_EN is defined.
module decode_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  decode_ctrl_if.slave bus
);

  logic [XLEN-1:0] w_instr;
  ctrl_t           w_ctrl;
  imm_sel_e        w_imm_sel;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_hazard;
  logic            w_ready;
  id_ex_t          w_next;
  id_ex_t          r_idex;

  assign w_instr = bus.id_instr;
  assign w_rd    = w_instr[11:7];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];

  decode_table u_dec (
    .i_opcode  (w_instr[6:0]),
    .i_valid   (bus.id_valid),
    .o_ctrl    (w_ctrl),
    .o_imm_sel (w_imm_sel),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

`ifdef DECODE_CTRL_HAZARD_EN
  assign w_hazard = bus.id_valid
                  && r_idex.valid
                  && r_idex.ctrl.mem_read
                  && (r_idex.rd != 5'd0)
                  && ((w_use_rs1 && (r_idex.rd == w_rs1))
                   || (w_use_rs2 && (r_idex.rd == w_rs2)));
`else
  assign w_hazard = 1'b0;
`endif

  always_comb begin
    w_next  = r_idex;
    w_ready = 1'b0;
    if (rst) begin
      w_next = ID_EX_BUBBLE;
    end else if (bus.ex_hold) begin
      w_next = r_idex;
    end else if (bus.ex_flush) begin
      w_next  = ID_EX_BUBBLE;
      w_ready = 1'b1;
    end else if (w_hazard) begin
      w_next = ID_EX_BUBBLE;
    end else begin
      w_next.valid = bus.id_valid;
      w_next.ctrl  = w_ctrl;
      w_next.rd    = w_rd;
      w_next.rs1   = w_rs1;
      w_next.rs2   = w_rs2;
      w_ready      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_idex <= ID_EX_BUBBLE;
    else     r_idex <= w_next;
  end

  assign bus.id_ready     = w_ready;
  assign bus.imm_sel      = w_imm_sel;
  assign bus.ex_valid     = r_idex.valid;
  assign bus.ex_reg_write = r_idex.ctrl.reg_write;
  assign bus.ex_mem_read  = r_idex.ctrl.mem_read;
  assign bus.ex_mem_write = r_idex.ctrl.mem_write;
  assign bus.ex_branch    = r_idex.ctrl.branch;
  assign bus.ex_jump      = r_idex.ctrl.jump;
  assign bus.ex_alu_src   = r_idex.ctrl.alu_src;
  assign bus.ex_utype     = r_idex.ctrl.utype;
  assign bus.ex_illegal   = r_idex.ctrl.illegal;
  assign bus.ex_alu_op    = r_idex.ctrl.alu_op;
  assign bus.ex_rd        = r_idex.rd;
  assign bus.ex_rs1       = r_idex.rs1;
  assign bus.ex_rs2       = r_idex.rs2;

endmodule

// File: tb/tb_decode_ctrl.sv
// Randomized + directed bench for decode_ctrl against a behavioural model.
module tb_decode_ctrl;

`ifdef DECODE_CTRL_HAZARD_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_ctrl_if bus ();

  decode_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic rw, mr, mw, br, jp, as, ut, il;
    logic [1:0] op;
    logic [1:0] imm;
    logic u1, u2;
  } ref_t;

  int n_err = 0;
  int n_chk = 0;

  logic       m_v, m_rw, m_mr, m_mw, m_br, m_jp, m_as, m_ut, m_il;
  logic [1:0] m_op;
  logic [4:0] m_rd, m_rs1, m_rs2;
  bit         m_known = 1'b0;
  bit         last_rdy;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ref_t ref_dec(input logic [31:0] ins);
    ref_t d;
    d = '0;
    case (ins[6:0])
      7'b0000011: begin d.mr = 1; d.rw = 1; d.as = 1; d.u1 = 1; end
      7'b0010011: begin d.rw = 1; d.as = 1; d.op = 2'b11; d.u1 = 1; end
      7'b1100111: begin d.jp = 1; d.rw = 1; d.as = 1; d.u1 = 1; end
      7'b0100011: begin
        d.imm = 2'b11; d.mw = 1; d.as = 1; d.u1 = 1; d.u2 = 1;
      end
      7'b1100011: begin
        d.imm = 2'b10; d.br = 1; d.op = 2'b01; d.u1 = 1; d.u2 = 1;
      end
      7'b1101111: begin d.imm = 2'b01; d.jp = 1; d.rw = 1; end
      7'b0110111, 7'b0010111: begin d.ut = 1; d.rw = 1; end
      7'b0110011: begin d.rw = 1; d.op = 2'b10; d.u1 = 1; d.u2 = 1; end
      default: d.il = 1;
    endcase
    return d;
  endfunction

  function automatic bit ref_haz(input logic v, input logic [31:0] ins);
    ref_t d;
    logic [4:0] srcs[$];
    bit hit;
    d = ref_dec(ins);
    hit = 1'b0;
    if (d.u1) srcs.push_back(ins[19:15]);
    if (d.u2) srcs.push_back(ins[24:20]);
    foreach (srcs[i]) if (srcs[i] == m_rd) hit = 1'b1;
    return HZ_EN && v && m_known && m_v && m_mr && (m_rd != 0) && hit;
  endfunction

  task automatic clear_model();
    {m_v, m_rw, m_mr, m_mw, m_br, m_jp, m_as, m_ut, m_il} = '0;
    m_op = '0;
    m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    m_known = 1'b1;
  endtask

  task automatic cyc(input bit r, input bit v, input logic [31:0] ins,
                     input bit h, input bit f);
    ref_t d;
    bit haz, rdy;
    logic [1:0] imm;
    @(negedge clk);
    rst = r;
    bus.id_valid = v;
    bus.id_instr = ins;
    bus.ex_hold  = h;
    bus.ex_flush = f;
    #1;
    d   = ref_dec(ins);
    haz = ref_haz(v, ins);
    imm = v ? d.imm : 2'b00;
    rdy = r ? 1'b0 : h ? 1'b0 : f ? 1'b1 : haz ? 1'b0 : 1'b1;
    chk("imm_sel", 32'(bus.imm_sel), 32'(imm));
    chk("id_ready", 32'(bus.id_ready), 32'(rdy));
    last_rdy = rdy;
    @(posedge clk);
    if (r) clear_model();
    else if (h) begin end
    else if (f || haz) clear_model();
    else begin
      m_v = v;
      {m_rw, m_mr, m_mw, m_br, m_jp, m_as, m_ut, m_il} =
        {d.rw, d.mr, d.mw, d.br, d.jp, d.as, d.ut, d.il};
      m_op = d.op;
      m_rd = ins[11:7]; m_rs1 = ins[19:15]; m_rs2 = ins[24:20];
      m_known = v;
    end
    #1;
    if (m_known || r) begin
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_v));
      chk("ex_ctrl",
          32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
               bus.ex_branch, bus.ex_jump, bus.ex_alu_src,
               bus.ex_utype, bus.ex_illegal, bus.ex_alu_op}),
          32'({m_rw, m_mr, m_mw, m_br, m_jp, m_as, m_ut, m_il, m_op}));
      chk("ex_idx", 32'({bus.ex_rd, bus.ex_rs1, bus.ex_rs2}),
          32'({m_rd, m_rs1, m_rs2}));
    end else begin
      chk("ex_valid_nv", 32'(bus.ex_valid), 32'(m_v));
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    int n = 0;
    cyc(0, 1, ins, 0, 0);
    while (!last_rdy && n < 4) begin
      cyc(0, 1, ins, 0, 0);
      n++;
    end
    if (!last_rdy) chk("issue_timeout", 32'(last_rdy), 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [9];
    logic [31:0] w;
    int k;
    opcs = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
             7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
             7'b0110011};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = opcs[k];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  localparam logic [31:0] ADDI = 32'h00A00093;
  localparam logic [31:0] LW5  = 32'h0002A283;
  localparam logic [31:0] ADD6 = 32'h00128333;
  localparam logic [31:0] LW0  = 32'h00002003;
  localparam logic [31:0] ADD0 = 32'h00100333;

  initial begin
    logic [31:0] cur;
    bit v, stall_seen;
    rst = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_instr = '0;
    bus.ex_hold  = 1'b0;
    bus.ex_flush = 1'b0;

    cyc(1, 1, ADDI, 0, 0);
    cyc(1, 1, ADDI, 0, 0);
    cyc(0, 1, ADDI, 0, 0);
    chk("rst_addi_rw", 32'(bus.ex_reg_write), 32'd1);

    issue(32'h00112023);
    issue(32'h00208463);
    issue(32'h008000EF);
    issue(32'h12345037);
    chk("lui_utype", 32'(bus.ex_utype), 32'd1);
    issue(32'hFFFFFFFF);
    chk("illegal", 32'(bus.ex_illegal), 32'd1);

    issue(LW5);
    cyc(0, 1, ADD6, 0, 0);
    stall_seen = !last_rdy;
    chk("lu_stall", 32'(stall_seen), 32'(HZ_EN));
    if (!last_rdy) cyc(0, 1, ADD6, 0, 0);
    chk("lu_issued", 32'(last_rdy), 32'd1);

    issue(LW0);
    cyc(0, 1, ADD0, 0, 0);
    chk("rd0_nostall", 32'(last_rdy), 32'd1);

    issue(ADDI);
    cyc(0, 1, ADD6, 0, 1);
    issue(LW5);
    cyc(0, 1, ADD6, 0, 1);
    chk("flush_haz_rdy", 32'(last_rdy), 32'd1);

    issue(LW5);
    cyc(0, 1, ADD6, 1, 0);
    cyc(0, 1, ADD6, 1, 1);
    cyc(0, 1, ADD6, 1, 0);
    issue(ADD6);

    issue(LW5);
    cyc(1, 1, ADD6, 0, 0);
    cyc(0, 1, ADD6, 0, 0);
    chk("post_rst_nostall", 32'(last_rdy), 32'd1);

    cur = rand_instr();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) != 0);
      cyc(($urandom_range(0, 99) == 0), v, cur,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      if (!v || last_rdy) cur = rand_instr();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Instruction-decode-stage controller for the pipelined RV32I core. Decodes the instruction held in the IF/ID register, drives the immediate generator's format select combinationally, and registers the control word into the ID/EX pipeline register. Also handles load-use stall insertion, branch/jump flush bubbles and downstream hold back-pressure between fetch and execute.

## Interface
- Parameters:
- `XLEN`, 32: instruction width; only 32 is supported.
- Ports (name, direction, width, meaning):
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `id_valid`, in, 1: IF/ID register holds a valid instruction.
- `id_instr`, in, 32: IF/ID instruction.
- `id_ready`, out, 1: ID consumes `id_instr` this cycle. Fetch advances IF/ID only when `id_valid && id_ready`.
- `imm_sel`, out, 2: combinational immediate format select for the immediate generator.
- `ex_hold`, in, 1: EX cannot accept; the ID/EX register freezes.
- `ex_flush`, in, 1: branch/jump taken in EX; squash the ID instruction.
- `ex_valid`, out, 1: ID/EX holds a valid instruction.
- `ex_reg_write`, out, 1: registered control outputs.
- `ex_mem_read`, out, 1: registered control outputs.
- `ex_mem_write`, out, 1: registered control outputs.
- `ex_branch`, out, 1: registered control outputs.
- `ex_jump`, out, 1: registered control outputs.
- `ex_alu_src`, out, 1: registered control outputs.
- `ex_utype`, out, 1: registered control outputs.
- `ex_illegal`, out, 1: registered control outputs.
- `ex_alu_op`, out, 2: 00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
- `ex_rd`, out, 5: registered register indices.
- `ex_rs1`, out, 5: registered register indices.
- `ex_rs2`, out, 5: registered register indices.

## Operation
- `imm_sel` encoding (fixed by the immediate generator): 00 I, 01 J, 10 B, 11 S.
- Decode by `id_instr[6:0]`:
  - LOAD 0000011: I, mem_read, reg_write, alu_src, alu_op 00.
  - OP-IMM 0010011: I, reg_write, alu_src, alu_op 11.
  - JALR 1100111: I, jump, reg_write, alu_src, alu_op 00.
  - STORE 0100011: S, mem_write, alu_src, alu_op 00.
  - BRANCH 1100011: B, branch, alu_op 01.
  - JAL 1101111: J, jump, reg_write.
  - LUI 0110111 / AUIPC 0010111: utype, reg_write, imm_sel 00. The datapath forms the U-immediate itself.
  - OP 0110011: reg_write, alu_op 10, imm_sel 00.
  - Any other opcode: illegal=1, with all write/mem/branch/jump controls 0.
- `imm_sel` is 00 whenever `id_valid=0`.
- rs1 is used by all types except LUI, AUIPC and JAL. rs2 is used by OP, STORE and BRANCH.
- Load-use hazard: `ex_valid && ex_mem_read && ex_rd!=0 && ((use_rs1 && ex_rd==rs1) || (use_rs2 && ex_rd==rs2))`, qualified by `id_valid`.
- Per-cycle priority (highest first):
  1. `rst`: ID/EX cleared.
  2. `ex_hold`: ID/EX unchanged; `id_ready=0`.
  3. `ex_flush`: ID/EX loads a bubble; `id_ready=1` (ID instruction dropped).
  4. hazard: ID/EX loads a bubble; `id_ready=0` (ID instruction retried next cycle).
  5. Otherwise: ID/EX loads the decoded word, with `ex_valid=id_valid`; `id_ready=1`.
- Bubble: `ex_valid=0` and all control bits 0. Register indices are don't-care but are driven to 0.

## Timing
- Reset: all ex_* outputs 0 on the first rising edge with `rst=1`. `id_ready` is 0 while `rst` is high. `imm_sel` stays combinational.
- `imm_sel` and `id_ready` are combinational, with zero latency from inputs.
- Decode-to-EX latency is 1 cycle.
- A load-use stall lasts exactly 1 cycle. The next cycle sees `ex_mem_read=0` (bubble), so the instruction issues.
- A flush during a hazard cycle takes the flush path; no stall is inserted.
- A hold during flush or hazard freezes ID/EX. Flush and hazard are re-evaluated when hold drops.
- Reset asserted mid-stall or mid-hold clears everything. There is no pending state after reset.

## Configuration
- `DECODE_CTRL_HAZARD_EN` defined: load-use detection active as above.
- Macro undefined: hazard term is constant 0, so the block never stalls (software-scheduled loads). All other behaviour is identical.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - opcode constants;
  - `imm_sel` encodings IMM_I/IMM_J/IMM_B/IMM_S;
  - `alu_op` encodings;
  - the control-word typedef.
- Sub-module `decode_table`: purely combinational opcode-to-control-word/imm_sel/use_rs decode. The top level contains the hazard logic, priority mux and ID/EX register.

## Test plan
- Reset: hold `rst` 2 cycles with `id_valid=1`, `id_instr=0x00A00093` -> all ex_* = 0 and `id_ready=0`. First cycle after reset: `imm_sel=00`. Next edge: `ex_reg_write=1`, `ex_alu_src=1`, `ex_alu_op=11`, `ex_rd=1`.
- Format select: 0x00112023 (sw) -> imm_sel 11; 0x00208463 (beq) -> 10; 0x008000EF (jal) -> 01; 0x12345037 (lui) -> 00 with `ex_utype=1`; 0xFFFFFFFF -> `ex_illegal=1`.
- Load-use: lw x5 (0x0002A283) then add x6,x5,x1 (0x00128333) -> one cycle with `id_ready=0` and `ex_valid=0`, then add issues. Same pair with `ex_rd=0` gives no stall. With the macro undefined there is never a stall.
- Flush: assert `ex_flush` with a valid ID instruction -> `id_ready=1` and `ex_valid=0` next cycle. Flush plus hazard in the same cycle -> flush wins, no stall.
- Hold: assert `ex_hold` 3 cycles -> ex_* stable and `id_ready=0`. Release -> the pending ID instruction issues in 1 cycle.
- Reset mid-stall: assert `rst` during a hazard cycle -> outputs 0; after release, the held instruction issues without a stall.
